// File: rtl/mv_ref_fetch_ctrl.sv
// MV-driven reference-row fetch sequencer: splits an MV pair into integer/phase and walks
// the interpolation window rows with picture-edge clamping. Option: MV_FETCH_FULLPEL_SKIP_EN.
module mv_ref_fetch_ctrl #(
    parameter int unsigned MV_W      = 19,
    parameter int unsigned FRAC_BITS = 4,
    parameter int unsigned BLK_W     = 8,
    parameter int unsigned BLK_H     = 8,
    parameter int unsigned TAPS      = 8,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned PIC_W     = 1920,
    parameter int unsigned PIC_H     = 1080
) (
    input  logic                 CLK,
    input  logic                 RST_SYNC,
    input  logic                 MV_VALID,
    output logic                 MV_READY,
    input  logic [MV_W-1:0]      MV_X_IN,
    input  logic [MV_W-1:0]      MV_Y_IN,
    input  logic [ADDR_W-1:0]    BLK_POS_X,
    input  logic [ADDR_W-1:0]    BLK_POS_Y,
    output logic [FRAC_BITS-1:0] FRAC_X,
    output logic [FRAC_BITS-1:0] FRAC_Y,
    output logic                 FETCH_VALID,
    input  logic                 FETCH_READY,
    output logic [ADDR_W-1:0]    FETCH_X,
    output logic [ADDR_W-1:0]    FETCH_Y,
    output logic                 FETCH_LAST,
    output logic                 BUSY
);

    localparam int unsigned CW     = ADDR_W + 3;
    localparam int unsigned MARGIN = TAPS / 2 - 1;
    localparam int unsigned NROWS  = BLK_H + TAPS - 1;
    localparam int unsigned RW     = $clog2(NROWS + 1);

    localparam logic [ADDR_W-1:0] X_MAX = ADDR_W'(PIC_W - 1);
    localparam logic [ADDR_W-1:0] Y_MAX = ADDR_W'(PIC_H - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_FETCH = 2'd2;

    // Row length is owned by the downstream filter; only reject a degenerate block here.
    if (BLK_W == 0 || BLK_H == 0) begin : g_cfg_err
        $error("mv_ref_fetch_ctrl: block dimensions must be non-zero");
    end

    logic [1:0]               state_q, state_d;
    logic signed [MV_W-1:0]   mv_x_q, mv_x_d, mv_y_q, mv_y_d;
    logic [ADDR_W-1:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [FRAC_BITS-1:0]     frac_x_q, frac_x_d, frac_y_q, frac_y_d;
    logic signed [CW-1:0]     org_y_q, org_y_d;
    logic [RW-1:0]            row_q, row_d, nrows_q, nrows_d;
    logic                     fetch_valid_q, fetch_valid_d;
    logic                     fetch_last_q, fetch_last_d;
    logic [ADDR_W-1:0]        fetch_x_q, fetch_x_d, fetch_y_q, fetch_y_d;
    logic                     mv_ready_q, mv_ready_d;
    logic                     busy_q, busy_d;

    logic signed [CW-1:0]     int_x_c, int_y_c, margin_c, org_x_c, org_y_c, row_y_c;
    logic [RW-1:0]            nrows_c, row_inc_c;

    function automatic logic [ADDR_W-1:0] clamp(input logic signed [CW-1:0] v,
                                                 input logic [ADDR_W-1:0]   max_v);
        if (v[CW-1]) begin
            return '0;
        end else if (v[CW-2:0] > {{(CW-1-ADDR_W){1'b0}}, max_v}) begin
            return max_v;
        end else begin
            return v[ADDR_W-1:0];
        end
    endfunction

    // Window geometry derived from the captured MV and block position.
    always_comb begin
        int_x_c = CW'(mv_x_q >>> FRAC_BITS);
        int_y_c = CW'(mv_y_q >>> FRAC_BITS);
`ifdef MV_FETCH_FULLPEL_SKIP_EN
        if (mv_x_q[FRAC_BITS-1:0] == '0 && mv_y_q[FRAC_BITS-1:0] == '0) begin
            margin_c = '0;
            nrows_c  = RW'(BLK_H);
        end else begin
            margin_c = CW'(MARGIN);
            nrows_c  = RW'(NROWS);
        end
`else
        margin_c = CW'(MARGIN);
        nrows_c  = RW'(NROWS);
`endif
        org_x_c   = $signed({{(CW-ADDR_W){1'b0}}, pos_x_q}) + int_x_c - margin_c;
        org_y_c   = $signed({{(CW-ADDR_W){1'b0}}, pos_y_q}) + int_y_c - margin_c;
        row_inc_c = row_q + RW'(1);
        row_y_c   = org_y_q + $signed({{(CW-RW){1'b0}}, row_inc_c});
    end

    always_comb begin
        state_d       = state_q;
        mv_x_d        = mv_x_q;
        mv_y_d        = mv_y_q;
        pos_x_d       = pos_x_q;
        pos_y_d       = pos_y_q;
        frac_x_d      = frac_x_q;
        frac_y_d      = frac_y_q;
        org_y_d       = org_y_q;
        row_d         = row_q;
        nrows_d       = nrows_q;
        fetch_valid_d = fetch_valid_q;
        fetch_last_d  = fetch_last_q;
        fetch_x_d     = fetch_x_q;
        fetch_y_d     = fetch_y_q;

        case (state_q)
            S_IDLE: begin
                if (MV_VALID && mv_ready_q) begin
                    mv_x_d  = MV_X_IN;
                    mv_y_d  = MV_Y_IN;
                    pos_x_d = BLK_POS_X;
                    pos_y_d = BLK_POS_Y;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                frac_x_d      = mv_x_q[FRAC_BITS-1:0];
                frac_y_d      = mv_y_q[FRAC_BITS-1:0];
                org_y_d       = org_y_c;
                nrows_d       = nrows_c;
                row_d         = '0;
                fetch_valid_d = 1'b1;
                fetch_x_d     = clamp(org_x_c, X_MAX);
                fetch_y_d     = clamp(org_y_c, Y_MAX);
                fetch_last_d  = (nrows_c == RW'(1));
                state_d       = S_FETCH;
            end
            S_FETCH: begin
                if (fetch_valid_q && FETCH_READY) begin
                    if (fetch_last_q) begin
                        fetch_valid_d = 1'b0;
                        fetch_last_d  = 1'b0;
                        state_d       = S_IDLE;
                    end else begin
                        row_d        = row_inc_c;
                        fetch_y_d    = clamp(row_y_c, Y_MAX);
                        fetch_last_d = (row_inc_c == nrows_q - RW'(1));
                    end
                end
            end
            default: begin
                fetch_valid_d = 1'b0;
                fetch_last_d  = 1'b0;
                state_d       = S_IDLE;
            end
        endcase

        mv_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST_SYNC) begin
            state_q       <= S_IDLE;
            mv_x_q        <= '0;
            mv_y_q        <= '0;
            pos_x_q       <= '0;
            pos_y_q       <= '0;
            frac_x_q      <= '0;
            frac_y_q      <= '0;
            org_y_q       <= '0;
            row_q         <= '0;
            nrows_q       <= '0;
            fetch_valid_q <= 1'b0;
            fetch_last_q  <= 1'b0;
            fetch_x_q     <= '0;
            fetch_y_q     <= '0;
            mv_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mv_x_q        <= mv_x_d;
            mv_y_q        <= mv_y_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            frac_x_q      <= frac_x_d;
            frac_y_q      <= frac_y_d;
            org_y_q       <= org_y_d;
            row_q         <= row_d;
            nrows_q       <= nrows_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_last_q  <= fetch_last_d;
            fetch_x_q     <= fetch_x_d;
            fetch_y_q     <= fetch_y_d;
            mv_ready_q    <= mv_ready_d;
            busy_q        <= busy_d;
        end
    end

    assign MV_READY    = mv_ready_q;
    assign FRAC_X      = frac_x_q;
    assign FRAC_Y      = frac_y_q;
    assign FETCH_VALID = fetch_valid_q;
    assign FETCH_X     = fetch_x_q;
    assign FETCH_Y     = fetch_y_q;
    assign FETCH_LAST  = fetch_last_q;
    assign BUSY        = busy_q;

endmodule

// File: tb/tb_mv_ref_fetch_ctrl.sv
// Directed self-checking bench for mv_ref_fetch_ctrl (default build or MV_FETCH_FULLPEL_SKIP_EN).
module tb_mv_ref_fetch_ctrl;

    localparam int X_MAX = 1919;
    localparam int Y_MAX = 1079;
`ifdef MV_FETCH_FULLPEL_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        CLK;
    logic        RST_SYNC;
    logic        MV_VALID;
    logic        MV_READY;
    logic [18:0] MV_X_IN;
    logic [18:0] MV_Y_IN;
    logic [11:0] BLK_POS_X;
    logic [11:0] BLK_POS_Y;
    logic [3:0]  FRAC_X;
    logic [3:0]  FRAC_Y;
    logic        FETCH_VALID;
    logic        FETCH_READY;
    logic [11:0] FETCH_X;
    logic [11:0] FETCH_Y;
    logic        FETCH_LAST;
    logic        BUSY;

    int total = 0;
    int bad   = 0;

    mv_ref_fetch_ctrl dut (
        .CLK         (CLK),
        .RST_SYNC    (RST_SYNC),
        .MV_VALID    (MV_VALID),
        .MV_READY    (MV_READY),
        .MV_X_IN     (MV_X_IN),
        .MV_Y_IN     (MV_Y_IN),
        .BLK_POS_X   (BLK_POS_X),
        .BLK_POS_Y   (BLK_POS_Y),
        .FRAC_X      (FRAC_X),
        .FRAC_Y      (FRAC_Y),
        .FETCH_VALID (FETCH_VALID),
        .FETCH_READY (FETCH_READY),
        .FETCH_X     (FETCH_X),
        .FETCH_Y     (FETCH_Y),
        .FETCH_LAST  (FETCH_LAST),
        .BUSY        (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic int clampv(input int v, input int mx);
        return (v < 0) ? 0 : ((v > mx) ? mx : v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mv_ready"}, 32'(MV_READY), 0);
        chk({tag, "_fvalid"},   32'(FETCH_VALID), 0);
        chk({tag, "_flast"},    32'(FETCH_LAST), 0);
        chk({tag, "_fx"},       32'(FETCH_X), 0);
        chk({tag, "_fy"},       32'(FETCH_Y), 0);
        chk({tag, "_frac_x"},   32'(FRAC_X), 0);
        chk({tag, "_frac_y"},   32'(FRAC_Y), 0);
        chk({tag, "_busy"},     32'(BUSY), 0);
    endtask

    // Entered at a negedge in IDLE; returns at the negedge of the first FETCH cycle.
    task automatic send_mv(input int px, input int py, input int mx, input int my,
                           input int efx, input int efy);
        chk("idle_mv_ready", 32'(MV_READY), 1);
        BLK_POS_X = px[11:0];
        BLK_POS_Y = py[11:0];
        MV_X_IN   = mx[18:0];
        MV_Y_IN   = my[18:0];
        MV_VALID  = 1'b1;
        @(posedge CLK); @(negedge CLK);
        MV_VALID = 1'b0;
        chk("calc_mv_ready", 32'(MV_READY), 0);
        chk("calc_busy",     32'(BUSY), 1);
        chk("calc_fvalid",   32'(FETCH_VALID), 0);
        @(posedge CLK); @(negedge CLK);
        chk("first_fvalid", 32'(FETCH_VALID), 1);
        chk("frac_x",       32'(FRAC_X), 32'(efx));
        chk("frac_y",       32'(FRAC_Y), 32'(efy));
    endtask

    // Walks rows until n_take handshakes are driven; the final handshake edge is left to the caller.
    task automatic take_rows(input int n_take, input int n_total, input int ox, input int oy,
                             input bit toggle);
        int cnt;
        cnt = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            chk("fvalid",   32'(FETCH_VALID), 1);
            chk("fx",       32'(FETCH_X), 32'(clampv(ox, X_MAX)));
            chk("fy",       32'(FETCH_Y), 32'(clampv(oy + cnt, Y_MAX)));
            chk("flast",    32'(FETCH_LAST), 32'(cnt == n_total - 1));
            chk("mv_ready", 32'(MV_READY), 0);
            FETCH_READY = toggle ? (cyc % 2 == 0) : 1'b1;
            if (FETCH_READY) cnt++;
            if (cnt == n_take) break;
            @(posedge CLK); @(negedge CLK);
        end
        chk("row_count", 32'(cnt), 32'(n_take));
    endtask

    task automatic run_case(input int px, input int py, input int mx, input int my,
                            input int efx, input int efy, input int ox, input int oy,
                            input int n, input bit toggle);
        send_mv(px, py, mx, my, efx, efy);
        take_rows(n, n, ox, oy, toggle);
        @(posedge CLK); @(negedge CLK);
        chk("end_fvalid",   32'(FETCH_VALID), 0);
        chk("end_mv_ready", 32'(MV_READY), 1);
        chk("end_busy",     32'(BUSY), 0);
        chk("end_frac_x",   32'(FRAC_X), 32'(efx));
        chk("end_frac_y",   32'(FRAC_Y), 32'(efy));
    endtask

    initial begin
        RST_SYNC    = 1'b1;
        MV_VALID    = 1'b0;
        FETCH_READY = 1'b0;
        MV_X_IN     = '0;
        MV_Y_IN     = '0;
        BLK_POS_X   = '0;
        BLK_POS_Y   = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_all_zero("reset");
        RST_SYNC = 1'b0;
        @(posedge CLK); @(negedge CLK);
        chk("post_reset_mv_ready", 32'(MV_READY), 1);

        // Quarter-ish phase horizontally, full-pel vertically.
        run_case(16, 16, 37, 16, 5, 0, 15, 14, 15, 1'b0);
        // Negative MVs: floor shift and 15/16 phase.
        run_case(100, 50, -1, -17, 15, 15, 96, 45, 15, 1'b0);
        // Top-left picture corner: rows clamp to 0.
        run_case(0, 0, -32, -32, 0, 0, SKIP ? -2 : -5, SKIP ? -2 : -5, SKIP ? 8 : 15, 1'b0);
        // Bottom-right corner: rows clamp to the last picture row.
        run_case(1912, 1072, 64, 64, 0, 0, SKIP ? 1916 : 1913, SKIP ? 1076 : 1073,
                 SKIP ? 8 : 15, 1'b0);
        // Back-pressure: ready toggling every cycle.
        run_case(16, 16, 37, 16, 5, 0, 15, 14, 15, 1'b1);

        // Reset collides with the fifth row handshake.
        send_mv(16, 16, 37, 16, 5, 0);
        take_rows(5, 15, 15, 14, 1'b0);
        RST_SYNC = 1'b1;
        @(posedge CLK); @(negedge CLK);
        chk_all_zero("midreset");
        RST_SYNC = 1'b0;
        @(posedge CLK); @(negedge CLK);
        chk("midreset_mv_ready", 32'(MV_READY), 1);
        run_case(16, 16, 37, 16, 5, 0, 15, 14, 15, 1'b0);

        // Full-pel MV: shrinks the window only when the skip option is built in.
        run_case(16, 16, 32, -16, 0, 0, SKIP ? 18 : 15, SKIP ? 15 : 12, SKIP ? 8 : 15, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
